// File: rtl/traffic_phase_sched_if.sv
// ============================================================================
// Module      : traffic_phase_sched_if
// Description : Signal bundle between the intersection phase scheduler and
//               its environment (tick strobe, vehicle sensors, lamp codes,
//               phase number, green-start pulse, optional pedestrian pair).
//   master : drives tick, ta, tb (and ped_req); observes the outputs
//   slave  : the scheduler itself
//   Optional feature macro: PED_WALK_EN adds ped_req / walk.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface traffic_phase_sched_if;
  logic       tick;
  logic       ta;
  logic       tb;
  logic [1:0] sa;
  logic [1:0] sb;
  logic [2:0] phase;
  logic       green_start;
`ifdef PED_WALK_EN
  logic       ped_req;
  logic       walk;
`endif

  modport master (
    output tick, ta, tb,
    input  sa, sb, phase, green_start
`ifdef PED_WALK_EN
    , output ped_req
    , input  walk
`endif
  );

  modport slave (
    input  tick, ta, tb,
    output sa, sb, phase, green_start
`ifdef PED_WALK_EN
    , input  ped_req
    , output walk
`endif
  );
endinterface

`default_nettype wire

// File: rtl/traffic_phase_sched.sv
// ============================================================================
// Module      : traffic_phase_sched
// Description : Demand-driven green/yellow/all-red phase scheduler for a
//               two-road intersection. All timing is counted in tick strobes.
//   clk    in  clock
//   reset  in  asynchronous, active-high reset
//   bus    traffic_phase_sched_if.slave:
//            tick, ta, tb (in)          timing strobe and vehicle sensors
//            sa, sb (out)               lamp codes r=00 y=01 g=10
//            phase (out)                state encoding
//            green_start (out)          1-clk pulse on green entry
//            ped_req (in), walk (out)   only with PED_WALK_EN
//   Optional feature macro: PED_WALK_EN (pedestrian walk phase).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_phase_sched #(
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1
`ifdef PED_WALK_EN
  , parameter int WALK_T  = 4
`endif
) (
  input  wire logic             clk,
  input  wire logic             reset,
  traffic_phase_sched_if.slave  bus
);

  localparam logic [1:0] c_lamp_r = 2'b00;
  localparam logic [1:0] c_lamp_y = 2'b01;
  localparam logic [1:0] c_lamp_g = 2'b10;

  // Timer compare points are "last tick of the interval" values.
  localparam logic [CNT_W-1:0] c_min_last = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] c_max_last = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] c_yel_last = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] c_clr_last = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] c_cnt_sat  = CNT_W'(MAX_GREEN - 1);
`ifdef PED_WALK_EN
  localparam logic [CNT_W-1:0] c_wlk_last = CNT_W'(WALK_T - 1);
`endif

`ifdef PED_WALK_EN
  typedef enum logic [2:0] {
    A_GRN = 3'd0, A_YEL = 3'd1, A_CLR = 3'd2,
    B_GRN = 3'd3, B_YEL = 3'd4, B_CLR = 3'd5,
    WALK  = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    A_GRN = 3'd0, A_YEL = 3'd1, A_CLR = 3'd2,
    B_GRN = 3'd3, B_YEL = 3'd4, B_CLR = 3'd5
  } state_t;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_green_start;
  logic             w_ped_dem;

`ifdef PED_WALK_EN
  logic r_ped_pend;
  logic r_from_a;     // WALK was entered from A_CLR, so it hands over to B

  assign w_ped_dem = r_ped_pend;
`else
  assign w_ped_dem = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state decision. Only consulted on a tick; uses the registered timer.
  // A pending pedestrian ends a green as soon as min-green is met, regardless
  // of demand on the serving road.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      A_GRN: begin
        if (r_cnt >= c_min_last &&
            (w_ped_dem || (bus.tb && (!bus.ta || r_cnt >= c_max_last))))
          w_next = A_YEL;
      end
      A_YEL: begin
        if (r_cnt == c_yel_last) w_next = A_CLR;
      end
      A_CLR: begin
        if (r_cnt == c_clr_last) begin
`ifdef PED_WALK_EN
          w_next = r_ped_pend ? WALK : B_GRN;
`else
          w_next = B_GRN;
`endif
        end
      end
      B_GRN: begin
        if (r_cnt >= c_min_last &&
            (w_ped_dem || (bus.ta && (!bus.tb || r_cnt >= c_max_last))))
          w_next = B_YEL;
      end
      B_YEL: begin
        if (r_cnt == c_yel_last) w_next = B_CLR;
      end
      B_CLR: begin
        if (r_cnt == c_clr_last) begin
`ifdef PED_WALK_EN
          w_next = r_ped_pend ? WALK : A_GRN;
`else
          w_next = A_GRN;
`endif
        end
      end
`ifdef PED_WALK_EN
      WALK: begin
        if (r_cnt == c_wlk_last) w_next = r_from_a ? B_GRN : A_GRN;
      end
`endif
      // Unreachable encodings recover through an all-red clearance.
      default: w_next = A_CLR;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, phase timer and green-start pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= A_GRN;
      r_cnt         <= '0;
      r_green_start <= 1'b0;
    end else begin
      r_green_start <= 1'b0;
      if (bus.tick) begin
        if (w_next != r_state) begin
          r_state       <= w_next;
          r_cnt         <= '0;
          r_green_start <= (w_next == A_GRN) || (w_next == B_GRN);
        end else if (r_cnt != c_cnt_sat) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

`ifdef PED_WALK_EN
  // The request latch clears only on the edge that enters WALK; a press
  // during WALK itself is kept for the next cycle of phases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ped_pend <= 1'b0;
      r_from_a   <= 1'b0;
    end else begin
      if (bus.tick && w_next == WALK && r_state != WALK) begin
        r_ped_pend <= 1'b0;
        r_from_a   <= (r_state == A_CLR);
      end else if (bus.ped_req) begin
        r_ped_pend <= 1'b1;
      end
    end
  end

  assign bus.walk = (r_state == WALK);
`endif

  // --------------------------------------------------------------------------
  // Moore lamp decode straight from the state register.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.sa = c_lamp_r;
    bus.sb = c_lamp_r;
    case (r_state)
      A_GRN:   bus.sa = c_lamp_g;
      A_YEL:   bus.sa = c_lamp_y;
      B_GRN:   bus.sb = c_lamp_g;
      B_YEL:   bus.sb = c_lamp_y;
      default: ;
    endcase
  end

  assign bus.phase       = r_state;
  assign bus.green_start = r_green_start;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_sched.sv
// ============================================================================
// Module      : tb_traffic_phase_sched
// Description : Directed, self-checking bench for traffic_phase_sched.
//               Table of single-clock vectors plus hand-written sequences
//               for rest-in-green, max-out cycling, tick gating, async reset
//               and (with PED_WALK_EN) the walk phase.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_sched;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  traffic_phase_sched_if bus ();

  traffic_phase_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       ta;
    logic       tb;
    logic [2:0] phase;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       gs;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [3:0] lamps(input logic [2:0] ph);
    case (ph)
      3'd0:    lamps = {G, R};
      3'd1:    lamps = {Y, R};
      3'd3:    lamps = {R, G};
      3'd4:    lamps = {R, Y};
      default: lamps = {R, R};
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h {phase,sa,sb,gs}", name, act, exp);
    end
  endtask

  // Compare packed {phase, sa, sb, green_start} against the phase-derived expectation.
  task automatic check_ph(input string name, input logic [2:0] ph, input logic gs);
    check(name, {bus.phase, bus.sa, bus.sb, bus.green_start}, {ph, lamps(ph), gs});
  endtask

  task automatic step(input logic tk, input logic a, input logic b);
    @(negedge clk);
    bus.tick = tk;
    bus.ta   = a;
    bus.tb   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    bus.tick = 1'b0;
    @(posedge clk);
    #1;
    check_ph("reset_state", 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset    = 1'b1;
    bus.tick = 1'b0;
    bus.ta   = 1'b0;
    bus.tb   = 1'b0;
`ifdef PED_WALK_EN
    bus.ped_req = 1'b0;
`endif

    // Gap-out from reset with ta=0, tb=1: yellow at tick 5, clear 3 ticks
    // later, B green one tick after that; then tick gating in B green.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 3'd0, G, R, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 3'd0, G, R, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 3'd0, G, R, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 3'd0, G, R, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 3'd1, Y, R, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 3'd1, Y, R, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 3'd1, Y, R, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 3'd2, R, R, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 3'd3, R, G, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 3'd3, R, G, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 3'd3, R, G, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 3'd3, R, G, 1'b0};

    // ---- rest in A green with no cross demand --------------------------
    do_reset();
    for (int k = 0; k < 50; k++) begin
      step(1'b1, 1'b1, 1'b0);
      check_ph("rest_a_green", 3'd0, 1'b0);
    end

    // ---- vector table ---------------------------------------------------
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].tick, vecs[i].ta, vecs[i].tb);
      check($sformatf("vec%0d", i),
            {bus.phase, bus.sa, bus.sb, bus.green_start},
            {vecs[i].phase, vecs[i].sa, vecs[i].sb, vecs[i].gs});
    end

    // ---- continuous demand: 20/3/1 per road, 48-tick cycle -------------
    do_reset();
    for (int k = 1; k <= 96; k++) begin
      int          m;
      logic [2:0]  ph;
      m  = k % 48;
      ph = (m < 20) ? 3'd0 : (m < 23) ? 3'd1 : (m < 24) ? 3'd2 :
           (m < 44) ? 3'd3 : (m < 47) ? 3'd4 : 3'd5;
      step(1'b1, 1'b1, 1'b1);
      check_ph($sformatf("maxout_k%0d", k), ph, (m == 24) || (m == 0));
    end

    // ---- tick every 4th clk, tb only high between ticks -----------------
    do_reset();
    for (int g = 0; g < 2; g++) begin
      step(1'b1, 1'b0, 1'b0);
      check_ph("sparse_tick", 3'd0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      check_ph("sparse_between", 3'd0, 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b1);
      check_ph("no_tick_hold", 3'd0, 1'b0);
    end
    // cnt must still be 2: two more ticks stay green, the third gaps out.
    step(1'b1, 1'b0, 1'b1);
    check_ph("cnt_hold_t1", 3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check_ph("cnt_hold_t2", 3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check_ph("cnt_hold_t3", 3'd1, 1'b0);

    // ---- asynchronous reset in the middle of A yellow -------------------
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b1);
    check_ph("pre_reset_yel", 3'd1, 1'b0);
    #2;
    reset    = 1'b1;
    bus.tick = 1'b0;
    #1;
    check_ph("async_reset", 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 1'b1);
      check_ph($sformatf("post_reset_k%0d", k), (k == 5) ? 3'd1 : 3'd0, 1'b0);
    end

`ifdef PED_WALK_EN
    // ---- pedestrian request at tick 2 -----------------------------------
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    bus.ped_req = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    bus.ped_req = 1'b0;
    for (int k = 3; k <= 13; k++) begin
      logic [2:0] ph;
      ph = (k < 5) ? 3'd0 : (k < 8) ? 3'd1 : (k < 9) ? 3'd2 :
           (k < 13) ? 3'd6 : 3'd3;
      step(1'b1, 1'b1, 1'b0);
      check_ph($sformatf("ped_k%0d", k), ph, k == 13);
      check($sformatf("walk_k%0d", k), {7'd0, bus.walk}, {7'd0, ph == 3'd6});
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
